// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-outstanding fetches over a
// req/ack handshake and presents instr/nextPC to decode, squashing on leaps.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        leap_in,
   input  logic [31:0] leapAddr_in,
   input  logic        stall_in,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   output logic [31:0] instr_out,
   output logic [31:0] nextPC_out,
   output logic        valid_out
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetchState_t;

   fetchState_t stateR, stateN;
   logic [31:0] pcR, pcN;
   logic        reqR, reqN;
   logic [31:0] addrR, addrN;
   logic [31:0] instrR, instrN;
   logic [31:0] nextPcR, nextPcN;
   logic        validR, validN;
   logic        squashR, squashN;

   logic        ackS;
   logic        consumeS;
   logic [31:0] pcPlus4S;
   logic [31:0] leapPcS;

   assign ackS     = imem_ack & reqR;
   assign consumeS = validR & ~stall_in;
   assign pcPlus4S = pcR + 32'd4;
   assign leapPcS  = leapAddr_in & 32'hFFFF_FFFC;

   // Next-state and next-output logic for the fetch FSM.
   always_comb begin
      stateN  = stateR;
      pcN     = pcR;
      reqN    = reqR;
      addrN   = addrR;
      instrN  = instrR;
      nextPcN = nextPcR;
      validN  = validR;
      squashN = squashR;
      if (leap_in) begin
         pcN    = leapPcS;
         validN = 1'b0;
         instrN = NOP_INSTR;
         stateN = FETCH;
         // An unanswered request must be allowed to finish; its data is dropped.
         if (reqR && !ackS) begin
            squashN = 1'b1;
         end else begin
            squashN = 1'b0;
            reqN    = 1'b1;
            addrN   = leapPcS;
         end
      end else begin
         if (consumeS) begin
            validN = 1'b0;
            instrN = NOP_INSTR;
         end else begin
            validN = validR;
            instrN = instrR;
         end
         case (stateR)
            BOOT: begin
               reqN   = 1'b1;
               addrN  = pcR;
               stateN = FETCH;
            end
            FETCH: begin
               if (!ackS) begin
                  reqN = 1'b1;
               end else if (squashR) begin
                  squashN = 1'b0;
                  reqN    = 1'b1;
                  addrN   = pcR;
               end else if (!stall_in) begin
                  instrN  = imem_data;
                  nextPcN = pcPlus4S;
                  validN  = 1'b1;
                  pcN     = pcPlus4S;
                  reqN    = 1'b1;
                  addrN   = pcPlus4S;
               end else if (!validR) begin
                  instrN  = imem_data;
                  nextPcN = pcPlus4S;
                  validN  = 1'b1;
                  pcN     = pcPlus4S;
                  reqN    = 1'b0;
                  stateN  = HOLD;
               end else begin
                  // Decode still holds an unconsumed word: drop this one, refetch pc later.
                  reqN   = 1'b0;
                  stateN = HOLD;
               end
            end
            HOLD: begin
               if (!stall_in) begin
                  reqN   = 1'b1;
                  addrN  = pcR;
                  stateN = FETCH;
               end else begin
                  reqN = 1'b0;
               end
            end
            default: begin
               stateN  = BOOT;
               reqN    = 1'b0;
               squashN = 1'b0;
               validN  = 1'b0;
               instrN  = NOP_INSTR;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateR  <= BOOT;
         pcR     <= RESET_PC;
         reqR    <= 1'b0;
         addrR   <= RESET_PC;
         instrR  <= NOP_INSTR;
         nextPcR <= RESET_PC;
         validR  <= 1'b0;
         squashR <= 1'b0;
      end else begin
         stateR  <= stateN;
         pcR     <= pcN;
         reqR    <= reqN;
         addrR   <= addrN;
         instrR  <= instrN;
         nextPcR <= nextPcN;
         validR  <= validN;
         squashR <= squashN;
      end
   end

   assign imem_req   = reqR;
   assign imem_addr  = addrR;
   assign instr_out  = instrR;
   assign nextPC_out = nextPcR;
   assign valid_out  = validR;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory responder, a stimulus driver that
// queues the expected program-order addresses, and a monitor that checks decode.
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0000;
   localparam int          NCYC     = 3000;

   logic        clk = 1'b0;
   logic        reset;
   logic        leap_in;
   logic [31:0] leapAddr_in;
   logic        stall_in;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic [31:0] instr_out;
   logic [31:0] nextPC_out;
   logic        valid_out;

   int nChecks = 0;
   int nPass = 0;
   int phase = 0;
   int cycNo = 0;
   int resetCount = 0;
   int consumed = 0;
   logic [31:0] expQ[$];
   logic [31:0] lastPushed;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .reset(reset), .leap_in(leap_in), .leapAddr_in(leapAddr_in),
      .stall_in(stall_in), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data), .instr_out(instr_out),
      .nextPC_out(nextPC_out), .valid_out(valid_out)
   );

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0001;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic startStream(input logic [31:0] a);
      expQ.delete();
      expQ.push_back(a);
      lastPushed = a;
   endtask

   // Instruction memory: random latency, checks address stability, spurious acks when idle.
   initial begin
      logic        busy;
      logic [31:0] busyAddr;
      int          waitN;
      busy = 1'b0; busyAddr = 32'd0; waitN = 0;
      imem_ack = 1'b0; imem_data = 32'd0;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            busy = 1'b0;
            imem_ack = 1'b0;
         end else if (imem_req) begin
            if (busy) check("addr_stable", imem_addr, busyAddr);
            else begin
               busy = 1'b1;
               busyAddr = imem_addr;
               waitN = (phase == 2) ? int'($urandom_range(0, 3)) : 0;
               check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            end
            if (waitN == 0) begin
               imem_ack = 1'b1;
               imem_data = memWord(imem_addr);
               busy = 1'b0;
            end else begin
               imem_ack = 1'b0;
               imem_data = $urandom;
               waitN--;
            end
         end else begin
            busy = 1'b0;
            imem_ack = ($urandom_range(0, 3) == 0);
            imem_data = $urandom;
         end
      end
   end

   // Monitor: pops expected addresses on each decode consumption, checks leaps and freezes.
   initial begin
      logic        leapPend, frozen;
      logic [31:0] leapExp, frInstr, frNext, e;
      int          seenReset;
      leapPend = 1'b0; frozen = 1'b0; seenReset = 0;
      leapExp = 32'd0; frInstr = 32'd0; frNext = 32'd0; e = 32'd0;
      forever begin
         @(negedge clk);
         #1;
         if (reset === 1'b1 && phase > 0) begin
            if (seenReset != resetCount) begin
               leapPend = 1'b0; frozen = 1'b0; seenReset = resetCount;
            end
            if (leapPend) begin
               check("leap_req", {31'd0, imem_req}, 32'd1);
               check("leap_addr", imem_addr, leapExp);
               check("leap_valid", {31'd0, valid_out}, 32'd0);
               leapPend = 1'b0;
            end
            if (frozen) begin
               check("stall_valid", {31'd0, valid_out}, 32'd1);
               check("stall_instr", instr_out, frInstr);
               check("stall_nextpc", nextPC_out, frNext);
               frozen = 1'b0;
            end
            if (!valid_out) check("nop_when_invalid", instr_out, NOP);
            if (phase == 1 && cycNo >= 1) check("stream_valid", {31'd0, valid_out}, 32'd1);
            if (leap_in) begin
               leapPend = 1'b1;
               leapExp = (imem_req && !imem_ack) ? imem_addr : (leapAddr_in & 32'hFFFF_FFFC);
            end else if (valid_out && !stall_in) begin
               if (expQ.size() == 0) check("queue_underflow", 32'd1, 32'd0);
               else begin
                  e = expQ.pop_front();
                  check("instr", instr_out, memWord(e));
                  check("nextpc", nextPC_out, e + 32'd4);
                  consumed++;
               end
            end else if (valid_out && stall_in) begin
               frozen = 1'b1;
               frInstr = instr_out;
               frNext = nextPC_out;
            end
         end
      end
   end

   // Stimulus: reset, a clean streaming phase, then random stalls, leaps and a mid-run reset.
   initial begin
      int          stallLeft;
      logic        didReset, doLeap;
      logic [31:0] tgt;
      stallLeft = 0; didReset = 1'b0; doLeap = 1'b0; tgt = 32'd0;
      reset = 1'b0; leap_in = 1'b0; stall_in = 1'b0; leapAddr_in = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, RESET_PC);
      check("rst_instr", instr_out, NOP);
      check("rst_nextpc", nextPC_out, RESET_PC);
      check("rst_valid", {31'd0, valid_out}, 32'd0);
      startStream(RESET_PC);
      phase = 1;
      reset = 1'b1;
      for (int c = 0; c < NCYC; c++) begin
         @(negedge clk);
         cycNo = c;
         if (c == 40) phase = 2;
         if (c == 0) begin
            check("boot_req", {31'd0, imem_req}, 32'd1);
            check("boot_addr", imem_addr, RESET_PC);
         end
         leap_in = 1'b0;
         leapAddr_in = $urandom;
         if (phase == 1) stall_in = 1'b0;
         else if (stallLeft > 0) begin
            stall_in = 1'b1;
            stallLeft--;
         end else if ($urandom_range(0, 9) == 0) begin
            stall_in = 1'b1;
            stallLeft = int'($urandom_range(0, 3));
         end else stall_in = 1'b0;
         if (phase == 2 && !didReset && c >= 1500 && imem_req) begin
            stall_in = 1'b0;
            #2 reset = 1'b0;
            resetCount++;
            #1;
            check("midrst_req", {31'd0, imem_req}, 32'd0);
            check("midrst_valid", {31'd0, valid_out}, 32'd0);
            @(negedge clk);
            reset = 1'b1;
            startStream(RESET_PC);
            didReset = 1'b1;
         end else if (phase == 2) begin
            doLeap = 1'b1;
            if (c == 60) tgt = 32'hFFFF_FFF2;
            else if (c == 100) tgt = 32'h0000_0102;
            else if ($urandom_range(0, 99) < 6)
               tgt = ($urandom_range(0, 2) == 0) ? {28'hFFF_FFFF, 4'($urandom_range(0, 15))} : $urandom;
            else doLeap = 1'b0;
            if (doLeap) begin
               leap_in = 1'b1;
               leapAddr_in = tgt;
               startStream(tgt & 32'hFFFF_FFFC);
            end
         end
         while (expQ.size() < 4) begin
            lastPushed = lastPushed + 32'd4;
            expQ.push_back(lastPushed);
         end
      end
      check("progress", (consumed >= 200) ? 32'd1 : 32'd0, 32'd1);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule
